multiplicacao_seq: RTL

MULTIPLICACAO_SEQ -- requirements
Module: multiplicacao_seq

---
 rtl/mult_pkg.sv | 18 +
 rtl/somador_rca.sv | 24 ++
 rtl/multiplicacao_seq.sv | 121 ++++++++++++
 3 files changed

// File: rtl/mult_pkg.sv
// Shared types and constants for the sequential shift-add multiplier.
package mult_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int WA_DEF = 5;
    localparam int WB_DEF = 4;

    // Iteration counter width: clog2(WB), never below one bit.
    function automatic int cnt_width(input int wb);
        return (wb > 1) ? $clog2(wb) : 1;
    endfunction

endpackage

// File: rtl/somador_rca.sv
// N-bit ripple-carry adder/subtractor: s = a + b, or a - b when sub=1 (modulo 2^N).
module somador_rca #(
    parameter int N = 9
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         sub,
    output logic [N-1:0] s
);

    always_comb begin
        logic         carry;
        logic [N-1:0] bx;
        // Subtraction is a + ~b + 1; the +1 enters as the initial carry.
        bx    = b ^ {N{sub}};
        carry = sub;
        s     = '0;
        for (int i = 0; i < N; i++) begin
            s[i]  = a[i] ^ bx[i] ^ carry;
            carry = (a[i] & bx[i]) | (carry & (a[i] ^ bx[i]));
        end
    end

endmodule

// File: rtl/multiplicacao_seq.sv
// Sequential radix-2 shift-add multiplier, one multiplier bit per cycle, LSB first.
// Define MULT_SIGNED_EN to enable two's-complement operation selected by is_signed.
module multiplicacao_seq
    import mult_pkg::*;
#(
    parameter int WA = WA_DEF,
    parameter int WB = WB_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          is_signed,
    input  logic [WA-1:0] a,
    input  logic [WB-1:0] b,
    output logic          busy,
    output logic          done,
    output logic [WA+WB-1:0] s
);

    localparam int W  = WA + WB;
    localparam int CW = cnt_width(WB);
    localparam logic [CW-1:0] LAST = CW'(WB - 1);

    state_t          state_q;
    state_t          state_d;
    logic            accept;
    logic            last_iter;
    logic            sub;
    logic [W-1:0]    acc_q;
    logic [W-1:0]    mcand_q;
    logic [W-1:0]    addend;
    logic [W-1:0]    sum;
    logic [W-1:0]    s_q;
    logic [WB-1:0]   mplier_q;
    logic [CW-1:0]   cnt_q;

    assign accept    = start && ((state_q == IDLE) || (state_q == DONE));
    assign last_iter = (cnt_q == LAST);
    assign addend    = mplier_q[0] ? mcand_q : '0;
    assign s         = s_q;

`ifdef MULT_SIGNED_EN
    logic                 mode_q;
    logic signed [WA-1:0] a_s;
    assign a_s = a;
    // The multiplier MSB carries weight -2^(WB-1) in signed mode.
    assign sub = mode_q && last_iter;
`else
    logic unused_is_signed;
    assign unused_is_signed = is_signed;
    assign sub = 1'b0;
`endif

    somador_rca #(
        .N(W)
    ) u_somador (
        .a  (acc_q),
        .b  (addend),
        .sub(sub),
        .s  (sum)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        busy    = 1'b0;
        done    = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) state_d = CALC;
            end
            CALC: begin
                busy = 1'b1;
                if (last_iter) state_d = DONE;
            end
            DONE: begin
                done    = 1'b1;
                state_d = accept ? CALC : IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Operand capture on acceptance, then one shift-add step per CALC cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
            s_q      <= '0;
`ifdef MULT_SIGNED_EN
            mode_q   <= 1'b0;
`endif
        end else if (accept) begin
            acc_q    <= '0;
            mplier_q <= b;
            cnt_q    <= '0;
`ifdef MULT_SIGNED_EN
            mode_q   <= is_signed;
            mcand_q  <= is_signed ? W'(a_s) : {{WB{1'b0}}, a};
`else
            mcand_q  <= {{WB{1'b0}}, a};
`endif
        end else if (state_q == CALC) begin
            acc_q    <= sum;
            mcand_q  <= mcand_q << 1;
            mplier_q <= mplier_q >> 1;
            cnt_q    <= cnt_q + CW'(1);
            if (last_iter) s_q <= sum;
        end
    end

endmodule
